// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch controller: prescaled tick, start/stop/clear/lap FSM and a
// 4-digit cascaded BCD count with a lap hold register for the display mux.
module bcd_stopwatch_ctrl #(
    parameter int TICK_DIV = 4,
    parameter bit WRAP     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        lap,
    output logic [15:0] digits_out,
    output logic        running,
    output logic        lap_active,
    output logic        tick,
    output logic        ovf
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

    localparam logic [15:0] DivMax = 16'(TICK_DIV - 1);

    state_e      state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [15:0] count_q, count_d;
    logic [15:0] lapVal_q, lapVal_d;
    logic        lapActive_q, lapActive_d;
    logic        tick_q, tick_d;
    logic        ovf_q, ovf_d;
    logic [15:0] countInc;
    logic        carry;
    logic        incr;
    logic        atMax;

    // A tick shown this cycle commits its increment only if the watch is not stopped or cleared now.
    assign incr  = tick_q && (state_q == RUN) && !clear && !stop;
    assign atMax = (count_q == 16'h9999);

    // Ripple the carry through the digits so no digit ever passes through 10-15.
    always_comb begin
        countInc = count_q;
        carry    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    countInc[4*i +: 4] = 4'd0;
                end else begin
                    countInc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry              = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN: begin
                    if (incr && atMax && !WRAP) state_d = DONE;
                    else if (stop)              state_d = PAUSE;
                end
                PAUSE:   if (!stop && start) state_d = RUN;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        running = (state_q == RUN);
    end

    always_comb begin
        presc_d     = presc_q;
        count_d     = count_q;
        lapVal_d    = lapVal_q;
        lapActive_d = lapActive_q;
        ovf_d       = ovf_q;
        if (clear) begin
            presc_d     = 16'd0;
            count_d     = 16'd0;
            lapVal_d    = 16'd0;
            lapActive_d = 1'b0;
            ovf_d       = 1'b0;
        end else begin
            if (state_q == RUN && !stop)
                presc_d = (presc_q == DivMax) ? 16'd0 : presc_q + 16'd1;
            if (incr)
                count_d = atMax ? (WRAP ? 16'd0 : count_q) : countInc;
            if (lap && (state_q == RUN || state_q == PAUSE)) begin
                if (lapActive_q) begin
                    lapActive_d = 1'b0;
                end else begin
                    lapVal_d    = count_q;
                    lapActive_d = 1'b1;
                end
            end
            if (WRAP) ovf_d = incr && atMax;
            else      ovf_d = ovf_q || (incr && atMax);
        end
        tick_d = (state_d == RUN) && (presc_d == DivMax);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= 16'd0;
            count_q     <= 16'd0;
            lapVal_q    <= 16'd0;
            lapActive_q <= 1'b0;
            tick_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            count_q     <= count_d;
            lapVal_q    <= lapVal_d;
            lapActive_q <= lapActive_d;
            tick_q      <= tick_d;
            ovf_q       <= ovf_d;
        end
    end

    assign digits_out = lapActive_q ? lapVal_q : count_q;
    assign lap_active = lapActive_q;
    assign tick       = tick_q;
    assign ovf        = ovf_q;

endmodule
